uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive buffer directly downstream of the UART RX frame FSM/deserializer. Captures each parallel byte when the FSM pulses data_valid and stores it in a power-of-2 circular buffer. Presents bytes to the consumer through a first-word-fall-through valid/ready interface. Reports fill level, overflow and an optional idle-timeout indication.

Parameters:
DATA_W, 8, byte width, matches deserializer output
DEPTH, 16, number of entries; power of 2, minimum 2
AFULL_TH, 12, level at or above which almost_full asserts; 1..DEPTH
TO_CYC, 1024, idle cycles before timeout; used only with the optional feature

Ports:
clk  in  1  system clock, same domain as the RX FSM
rst  in  1  synchronous, active-high reset
wr_data  in  DATA_W  parallel byte from the deserializer
wr_valid  in  1  single-cycle data_valid pulse from the RX FSM
rd_data  out  DATA_W  head-of-queue byte; valid while rd_valid=1
rd_valid  out  1  FIFO holds at least one byte
rd_ready  in  1  consumer accepts rd_data this cycle
level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
empty  out  1  level==0
full  out  1  level==DEPTH
almost_full  out  1  level>=AFULL_TH
ovf  out  1  sticky overflow flag
ovf_clr  in  1  clears ovf
ovf_cnt  out  8  count of dropped bytes, saturates at 255, cleared by ovf_clr
timeout  out  1  present only with RX_TIMEOUT_EN

Behaviour:
- Reset, synchronous on rst=1: pointers=0, level=0, empty=1, full=0, almost_full=0, rd_valid=0, rd_data=0, ovf=0, ovf_cnt=0, timeout=0. Storage contents are don't-care.
- Write accept: wr_valid=1 and (full=0, or rd_valid&rd_ready in the same cycle). The byte is written at wr_ptr, and wr_ptr advances modulo DEPTH.
- Read handshake: rd_valid&rd_ready. rd_ptr advances modulo DEPTH. On the next edge rd_data shows the following entry.
- rd_valid, rd_data and all status outputs are registered.
- Write into an empty FIFO: rd_valid=1 and rd_data=byte on the cycle after the write edge. Write-to-read latency is 1 cycle.
- level update rules:
  - +1 on write only
  - -1 on read only
  - unchanged on simultaneous write and read
- rd_valid==!empty at all times.
- Pointers carry an extra wrap bit. full/empty derive from the pointers, and level = wr_ptr - rd_ptr.
- Overflow: wr_valid=1 while full=1 and no read in that cycle.
  - The byte is dropped and contents are unchanged.
  - ovf is set on the next edge.
  - ovf_cnt increments and saturates at 255.
- Full plus simultaneous read and write: the write is accepted, there is no overflow, and level stays at DEPTH.
- ovf_clr=1 clears ovf and ovf_cnt. If an overflow occurs in the same cycle, set wins: ovf=1 and ovf_cnt=1.
- rd_ready while empty: no effect, no underflow.
- wr_valid is a pulse from the FSM. A held-high wr_valid writes once per cycle; no edge detection is applied.
- rst mid-stream: all contents are discarded, and the FSM's in-flight frame is unaffected.

Optional Feature:
- Macro: RX_TIMEOUT_EN
- Defined:
  - A 16-bit idle counter resets to 0 on any accepted write or any read handshake, and when empty=1.
  - Otherwise the counter increments, saturating.
  - timeout=1 while the counter equals TO_CYC and the FIFO is non-empty. It signals a stale partial burst for a low-watermark interrupt.
  - timeout clears on the next write or read.
- Undefined:
  - Counter logic is absent.
  - The timeout port is still present and tied to 0.
  - TO_CYC is ignored.

Decomposition:
- Shared package uart_rx_pkg:
  - DATA_W default
  - FIFO DEPTH default
  - function clog2-based pointer width
  - constant OVF_CNT_MAX=8'hFF
- One natural sub-module: uart_rx_fifo_mem, a simple dual-port register array with synchronous write and asynchronous read. Pointer, flag and handshake logic stay in uart_rx_fifo.

Test Plan:
- Single byte: after reset, wr_valid pulse with wr_data=8'hA5, rd_ready=0. Next cycle: rd_valid=1, rd_data=A5, level=1. Then rd_ready=1 for 1 cycle: empty=1, level=0.
- Fill and wrap: write 0x00..0x0F (DEPTH=16).
  - full=1 and level=16; almost_full rises when level reaches 12.
  - Drain 8 bytes, write 0x10..0x17, drain all: read order is 0x08..0x17 in sequence.
- Overflow: with the FIFO full, write 3 more bytes with rd_ready=0: ovf=1, ovf_cnt=3, contents unchanged. Then ovf_clr=1: ovf=0, ovf_cnt=0.
- Full plus simultaneous read and write: FIFO full, wr_valid=1 and rd_ready=1 in the same cycle: ovf stays 0, level stays 16, and the new byte is read last.
- Reset mid-stream: 5 bytes stored, rst=1 for 1 cycle: empty=1, rd_valid=0, level=0, ovf=0. The next write of 8'h3C appears as the first read.
- RX_TIMEOUT_EN with TO_CYC=20: write 1 byte, idle: timeout=1 after the 20th idle cycle. One read handshake: timeout=0 and empty=1.

Source files
------------

// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared defaults and helpers for the UART receive FIFO slice.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 16;
    localparam logic [7:0] OVF_CNT_MAX = 8'hFF;

    // Pointer width carries one extra wrap bit above the address bits.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo_if
// Description : Write/read handshake and status bundle of the RX FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    logic [DATA_W-1:0]        wr_data;
    logic                     wr_valid;
    logic [DATA_W-1:0]        rd_data;
    logic                     rd_valid;
    logic                     rd_ready;
    logic [$clog2(DEPTH):0]   level;
    logic                     empty;
    logic                     full;
    logic                     almost_full;
    logic                     ovf;
    logic                     ovf_clr;
    logic [7:0]               ovf_cnt;
    logic                     timeout;

    modport master (
        output wr_data, wr_valid, rd_ready, ovf_clr,
        input  rd_data, rd_valid, level, empty, full, almost_full,
               ovf, ovf_cnt, timeout
    );

    modport slave (
        input  wr_data, wr_valid, rd_ready, ovf_clr,
        output rd_data, rd_valid, level, empty, full, almost_full,
               ovf, ovf_cnt, timeout
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo_mem
// Description : Dual-port register array, synchronous write, async read.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  wire logic                     clk,
    input  wire logic                     i_we,
    input  wire logic [$clog2(DEPTH)-1:0] i_waddr,
    input  wire logic [DATA_W-1:0]        i_wdata,
    input  wire logic [$clog2(DEPTH)-1:0] i_raddr,
    output      logic [DATA_W-1:0]        o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : FWFT receive FIFO behind the UART deserializer with level,
//               overflow and (with RX_TIMEOUT_EN defined) idle timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int AFULL_TH = 12,
    parameter int TO_CYC   = 1024
) (
    input wire logic        clk,
    input wire logic        rst,
    uart_rx_fifo_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_w(DEPTH);
    localparam logic [PW-1:0] c_AFULL_TH = PW'(AFULL_TH);
    localparam logic [15:0]   c_TO_CYC   = 16'(TO_CYC);

    logic [PW-1:0]     r_wr_ptr, r_rd_ptr, r_level;
    logic [PW-1:0]     w_wr_nxt, w_rd_nxt, w_level_nxt;
    logic              r_empty, r_full, r_afull, r_rd_valid, r_ovf, r_timeout;
    logic [7:0]        r_ovf_cnt;
    logic [DATA_W-1:0] r_rd_data, w_head_nxt, w_mem_rdata;
    logic              w_rd_hs, w_wr_acc, w_ovf_ev, w_empty_nxt, w_full_nxt;

    always_comb begin
        w_rd_hs  = r_rd_valid & bus.rd_ready;
        w_wr_acc = bus.wr_valid & (~r_full | w_rd_hs);
        w_ovf_ev = bus.wr_valid & r_full & ~w_rd_hs;
        w_wr_nxt = w_wr_acc ? r_wr_ptr + PW'(1) : r_wr_ptr;
        w_rd_nxt = w_rd_hs  ? r_rd_ptr + PW'(1) : r_rd_ptr;
        w_level_nxt = w_wr_nxt - w_rd_nxt;
        w_empty_nxt = (w_wr_nxt == w_rd_nxt);
        w_full_nxt  = (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]) &&
                      (w_wr_nxt[AW] != w_rd_nxt[AW]);
        // The new head may be the byte being written this very cycle.
        w_head_nxt = (w_wr_acc && (w_rd_nxt == r_wr_ptr)) ? bus.wr_data
                                                           : w_mem_rdata;
    end

    uart_rx_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (bus.wr_data),
        .i_raddr (w_rd_nxt[AW-1:0]),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_afull    <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_wr_ptr   <= w_wr_nxt;
            r_rd_ptr   <= w_rd_nxt;
            r_level    <= w_level_nxt;
            r_empty    <= w_empty_nxt;
            r_full     <= w_full_nxt;
            r_afull    <= (w_level_nxt >= c_AFULL_TH);
            r_rd_valid <= ~w_empty_nxt;
            r_rd_data  <= w_head_nxt;
        end
    end

    // A drop in the same cycle as a clear wins over the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf     <= 1'b0;
            r_ovf_cnt <= '0;
        end else if (w_ovf_ev) begin
            r_ovf <= 1'b1;
            if (bus.ovf_clr) begin
                r_ovf_cnt <= 8'd1;
            end else if (r_ovf_cnt != OVF_CNT_MAX) begin
                r_ovf_cnt <= r_ovf_cnt + 8'd1;
            end
        end else if (bus.ovf_clr) begin
            r_ovf     <= 1'b0;
            r_ovf_cnt <= '0;
        end
    end

`ifdef RX_TIMEOUT_EN
    logic [15:0] r_idle_cnt, w_idle_nxt;

    always_comb begin
        w_idle_nxt = r_idle_cnt;
        if (w_wr_acc || w_rd_hs || r_empty) begin
            w_idle_nxt = '0;
        end else if (r_idle_cnt != 16'hFFFF) begin
            w_idle_nxt = r_idle_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_idle_cnt <= w_idle_nxt;
            r_timeout  <= (w_idle_nxt == c_TO_CYC) && ~w_empty_nxt;
        end
    end
`else
    logic w_unused_to;
    assign w_unused_to = ^c_TO_CYC;
    assign r_timeout   = 1'b0;
`endif

    assign bus.rd_data     = r_rd_data;
    assign bus.rd_valid    = r_rd_valid;
    assign bus.level       = r_level;
    assign bus.empty       = r_empty;
    assign bus.full        = r_full;
    assign bus.almost_full = r_afull;
    assign bus.ovf         = r_ovf;
    assign bus.ovf_cnt     = r_ovf_cnt;
    assign bus.timeout     = r_timeout;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Self-checking bench for uart_rx_fifo (DEPTH=16, AFULL_TH=12).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DATA_W(8), .DEPTH(16)) bus ();

    uart_rx_fifo #(
        .DATA_W   (8),
        .DEPTH    (16),
        .AFULL_TH (12),
        .TO_CYC   (20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       rs;
        logic       wv;
        logic [7:0] wd;
        logic       rr;
        logic       oc;
        logic       ev;
        logic [7:0] ed;
        logic [4:0] el;
        logic       ee;
        logic       ef;
        logic       ea;
        logic       eo;
        logic [7:0] ec;
        logic       cd;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic rs, input logic wv, input logic [7:0] wd,
                        input logic rr, input logic oc);
        rst          = rs;
        bus.wr_valid = wv;
        bus.wr_data  = wd;
        bus.rd_ready = rr;
        bus.ovf_clr  = oc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_lvl(input string tag, input int lvl);
        chk({tag, " level"}, 32'(bus.level), 32'(lvl));
        chk({tag, " empty"}, 32'(bus.empty), 32'(lvl == 0));
        chk({tag, " full"},  32'(bus.full),  32'(lvl == 16));
        chk({tag, " afull"}, 32'(bus.almost_full), 32'(lvl >= 12));
        chk({tag, " rd_valid"}, 32'(bus.rd_valid), 32'(lvl != 0));
    endtask

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;
        bus.ovf_clr  = 1'b0;

        //            rs wv wd     rr oc  ev ed     el ee ef ea eo ec    cd
        vt[0]  = '{1, 0, 8'h00, 0, 0,  0, 8'h00, 0, 1, 0, 0, 0, 8'd0, 1};
        vt[1]  = '{0, 1, 8'hA5, 0, 0,  1, 8'hA5, 1, 0, 0, 0, 0, 8'd0, 1};
        vt[2]  = '{0, 0, 8'h00, 0, 0,  1, 8'hA5, 1, 0, 0, 0, 0, 8'd0, 1};
        vt[3]  = '{0, 0, 8'h00, 1, 0,  0, 8'h00, 0, 1, 0, 0, 0, 8'd0, 0};
        vt[4]  = '{0, 0, 8'h00, 1, 0,  0, 8'h00, 0, 1, 0, 0, 0, 8'd0, 0};
        vt[5]  = '{0, 1, 8'h11, 0, 0,  1, 8'h11, 1, 0, 0, 0, 0, 8'd0, 1};
        vt[6]  = '{0, 1, 8'h22, 0, 0,  1, 8'h11, 2, 0, 0, 0, 0, 8'd0, 1};
        vt[7]  = '{0, 1, 8'h33, 1, 0,  1, 8'h22, 2, 0, 0, 0, 0, 8'd0, 1};
        vt[8]  = '{0, 0, 8'h00, 1, 0,  1, 8'h33, 1, 0, 0, 0, 0, 8'd0, 1};
        vt[9]  = '{0, 1, 8'h44, 1, 0,  1, 8'h44, 1, 0, 0, 0, 0, 8'd0, 1};
        vt[10] = '{0, 0, 8'h00, 1, 0,  0, 8'h00, 0, 1, 0, 0, 0, 8'd0, 0};

        for (int i = 0; i < 11; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            step(vt[i].rs, vt[i].wv, vt[i].wd, vt[i].rr, vt[i].oc);
            chk({t, " rd_valid"}, 32'(bus.rd_valid), 32'(vt[i].ev));
            chk({t, " level"},    32'(bus.level),    32'(vt[i].el));
            chk({t, " empty"},    32'(bus.empty),    32'(vt[i].ee));
            chk({t, " full"},     32'(bus.full),     32'(vt[i].ef));
            chk({t, " afull"},    32'(bus.almost_full), 32'(vt[i].ea));
            chk({t, " ovf"},      32'(bus.ovf),      32'(vt[i].eo));
            chk({t, " ovf_cnt"},  32'(bus.ovf_cnt),  32'(vt[i].ec));
            chk({t, " timeout"},  32'(bus.timeout),  32'd0);
            if (vt[i].cd) chk({t, " rd_data"}, 32'(bus.rd_data), 32'(vt[i].ed));
        end

        // Fill and wrap, starting from non-zero pointers
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 8'(i), 0, 0);
            chk_lvl($sformatf("fill%0d", i), i + 1);
        end
        chk("fill head", 32'(bus.rd_data), 32'h00);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drainA%0d data", i), 32'(bus.rd_data), 32'(i));
            step(0, 0, 8'h00, 1, 0);
        end
        chk_lvl("drainA", 8);
        for (int i = 0; i < 8; i++) step(0, 1, 8'(8'h10 + i), 0, 0);
        chk_lvl("refill", 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drainB%0d data", i), 32'(bus.rd_data), 32'(8 + i));
            step(0, 0, 8'h00, 1, 0);
        end
        chk_lvl("drainB", 0);

        // Overflow, saturation and clear
        for (int i = 0; i < 16; i++) step(0, 1, 8'(8'h40 + i), 0, 0);
        chk("pre-ovf", 32'(bus.ovf), 32'd0);
        for (int i = 0; i < 3; i++) step(0, 1, 8'(8'h90 + i), 0, 0);
        chk("ovf flag", 32'(bus.ovf), 32'd1);
        chk("ovf_cnt3", 32'(bus.ovf_cnt), 32'd3);
        chk_lvl("ovf", 16);
        chk("ovf head", 32'(bus.rd_data), 32'h40);
        for (int i = 0; i < 257; i++) step(0, 1, 8'hBB, 0, 0);
        chk("ovf_cnt sat", 32'(bus.ovf_cnt), 32'hFF);
        step(0, 0, 8'h00, 0, 1);
        chk("clr ovf", 32'(bus.ovf), 32'd0);
        chk("clr cnt", 32'(bus.ovf_cnt), 32'd0);
        step(0, 1, 8'hCC, 0, 1);
        chk("clr+ovf flag", 32'(bus.ovf), 32'd1);
        chk("clr+ovf cnt", 32'(bus.ovf_cnt), 32'd1);
        step(0, 0, 8'h00, 0, 1);
        chk("clr2 cnt", 32'(bus.ovf_cnt), 32'd0);

        // Full plus simultaneous read and write
        step(0, 1, 8'hEE, 1, 0);
        chk("simul ovf", 32'(bus.ovf), 32'd0);
        chk_lvl("simul", 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drainC%0d data", i), 32'(bus.rd_data),
                (i == 15) ? 32'hEE : 32'(8'h41 + i));
            step(0, 0, 8'h00, 1, 0);
        end
        chk_lvl("drainC", 0);
        chk("drainC ovf", 32'(bus.ovf), 32'd0);

        // Reset mid-stream
        for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h70 + i), 0, 0);
        chk_lvl("pre-rst", 5);
        step(1, 0, 8'h00, 0, 0);
        chk_lvl("post-rst", 0);
        chk("post-rst ovf", 32'(bus.ovf), 32'd0);
        chk("post-rst data", 32'(bus.rd_data), 32'd0);
        step(0, 1, 8'h3C, 0, 0);
        chk("after-rst data", 32'(bus.rd_data), 32'h3C);
        chk_lvl("after-rst", 1);

`ifdef RX_TIMEOUT_EN
        for (int i = 0; i < 19; i++) step(0, 0, 8'h00, 0, 0);
        chk("to 19", 32'(bus.timeout), 32'd0);
        step(0, 0, 8'h00, 0, 0);
        chk("to 20", 32'(bus.timeout), 32'd1);
        step(0, 0, 8'h00, 1, 0);
        chk("to clr", 32'(bus.timeout), 32'd0);
        chk("to empty", 32'(bus.empty), 32'd1);
`else
        for (int i = 0; i < 25; i++) step(0, 0, 8'h00, 0, 0);
        chk("timeout tied", 32'(bus.timeout), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
